ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported RAM between the instruction-fetch side (`i*`) and the data-memory side (`d*`) of the pipelined datapath. It sits between the datapath's cache interface and RAM. It grants one requester at a time, holds the grant until RAM signals completion, and returns the `iwait`/`dwait` handshakes that the datapath turns into `ihit`/`dhit`. Data accesses have priority. A streak limit keeps instruction fetch from starving, and a timeout reports a RAM that never responds.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_pick.sv | 22 ++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared grant-state type and default parameters for ram_arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MAX_DSTREAK = 4;
    localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - next-grant selection: data first unless instruction side hit its streak limit
module arb_pick
    import arb_pkg::*;
#(
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int SW          = $clog2(MAX_DSTREAK + 1)
) (
    input  logic          ireq,
    input  logic          dreq,
    input  logic [SW-1:0] dstreak,
    output arb_state_t    pick
);

    always_comb begin
        pick = IDLE;
        if (dreq && !(ireq && dstreak == SW'(MAX_DSTREAK)))
            pick = DGNT;
        else if (ireq)
            pick = IGNT;
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-ported RAM between instruction fetch and data access
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = $clog2(TIMEOUT);

    arb_state_t    state, nxt, pick;
    logic [SW-1:0] dstreak;
    logic [TW-1:0] tcnt;
    logic          dreq, gnt_req, arb, abort;

    assign dreq = dREN | dWEN;

    arb_pick #(.MAX_DSTREAK(MAX_DSTREAK), .SW(SW)) u_pick (
        .ireq    (iREN),
        .dreq    (dreq),
        .dstreak (dstreak),
        .pick    (pick)
    );

    // Completion beats a same-cycle request drop; withdraw only applies without ram_ready.
    always_comb begin
        nxt     = state;
        arb     = 1'b0;
        abort   = 1'b0;
        gnt_req = (state == IGNT) ? iREN : dreq;
        case (state)
            IDLE: begin
                nxt = pick;
                arb = 1'b1;
            end
            IGNT, DGNT: begin
                if (ram_ready) begin
                    nxt = pick;
                    arb = 1'b1;
                end else if (!gnt_req) begin
                    nxt = IDLE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    nxt   = IDLE;
                    abort = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            dstreak <= '0;
            tcnt    <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            err   <= abort;
            if (state != IDLE && !arb && nxt == state)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (!iREN || (arb && nxt == IGNT))
                dstreak <= '0;
            else if (arb && nxt == DGNT && dstreak != SW'(MAX_DSTREAK))
                dstreak <= dstreak + SW'(1);
        end
    end

    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        iload     = '0;
        dload     = '0;
        case (state)
            IGNT: begin
                ram_ren  = 1'b1;
                ram_addr = iaddr;
                iload    = ram_rdata;
            end
            DGNT: begin
                ram_ren   = dREN;
                ram_wen   = dWEN;
                ram_addr  = daddr;
                ram_wdata = dstore;
                dload     = ram_rdata;
            end
            default: ;
        endcase
    end

    assign iwait = iREN & ~(state == IGNT & ram_ready);
    assign dwait = dreq & ~(state == DGNT & ram_ready);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against an owner-based model
module tb_ram_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN, dREN, dWEN, ram_ready;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore, ram_rdata;
    logic [DW-1:0] iload, dload, ram_wdata;
    logic [AW-1:0] ram_addr;
    logic          iwait, dwait, ram_ren, ram_wen, err;

    int checks   = 0;
    int failures = 0;

    int m_own    = 0;
    int m_streak = 0;
    int m_tc     = 0;
    bit m_err    = 1'b0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXS), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Owner: 0 nobody, 1 instruction side, 2 data side.
    function automatic int pick_m(input bit dq);
        if (dq && !(iREN && m_streak == MAXS)) return 2;
        if (iREN) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_own = 0; m_streak = 0; m_tc = 0; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit dq, arb, ab;
        int nx;
        dq = dREN | dWEN; arb = 0; ab = 0;
        if (m_own == 0 || ram_ready) begin
            nx = pick_m(dq); arb = 1;
        end else if (!(m_own == 1 ? iREN : dq)) begin
            nx = 0;
        end else if (m_tc == TO - 1) begin
            nx = 0; ab = 1;
        end else begin
            nx = m_own;
        end
        m_tc = (m_own != 0 && !arb && nx == m_own) ? m_tc + 1 : 0;
        if (!iREN || (arb && nx == 1)) m_streak = 0;
        else if (arb && nx == 2) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        m_err = ab;
        m_own = nx;
    endtask

    initial forever begin
        @(posedge CLK);
        if (!nRST) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (!nRST) model_reset();
        chk("ram_ren",   ram_ren,   m_own == 1 ? 1'b1 : (m_own == 2 ? dREN : 1'b0));
        chk("ram_wen",   ram_wen,   m_own == 2 ? dWEN : 1'b0);
        chk("ram_addr",  ram_addr,  m_own == 1 ? iaddr : (m_own == 2 ? daddr : '0));
        chk("ram_wdata", ram_wdata, m_own == 2 ? dstore : '0);
        chk("iload",     iload,     m_own == 1 ? ram_rdata : '0);
        chk("dload",     dload,     m_own == 2 ? ram_rdata : '0);
        chk("iwait",     iwait,     iREN && !(m_own == 1 && ram_ready));
        chk("dwait",     dwait,     (dREN | dWEN) && !(m_own == 2 && ram_ready));
        chk("err",       err,       m_err);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ram_rdata = '0;
    endtask

    initial begin
        nRST = 1'b0;
        clear_in();
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_ren", ram_ren, 1'b0);
        chk("rst_err", err, 1'b0);
        tick(); nRST = 1'b1;
        tick();

        // single fetch
        iREN = 1; iaddr = 32'h100;
        @(negedge CLK); chk("sf_wait_idle", iwait, 1'b1);
        tick(); @(negedge CLK);
        chk("sf_ren", ram_ren, 1'b1); chk("sf_addr", ram_addr, 64'h100);
        tick();
        tick(); ram_ready = 1; ram_rdata = 32'hDEADBEEF;
        @(negedge CLK);
        chk("sf_iwait", iwait, 1'b0); chk("sf_iload", iload, 64'hDEADBEEF);
        tick(); clear_in();
        repeat (2) tick();

        // simultaneous requests: data first, then instruction
        iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h200; dstore = 32'h55;
        tick(); @(negedge CLK);
        chk("sim_wen", ram_wen, 1'b1); chk("sim_wdata", ram_wdata, 64'h55);
        chk("sim_addr", ram_addr, 64'h200);
        tick(); ram_ready = 1; dWEN = 0;
        tick(); ram_ready = 0; @(negedge CLK);
        chk("sim_ignt_ren", ram_ren, 1'b1); chk("sim_ignt_addr", ram_addr, 64'h300);
        tick(); ram_ready = 1;
        tick(); clear_in();
        repeat (2) tick();

        // starvation limit: D,D,D,D,I repeating
        dREN = 1; iREN = 1; ram_ready = 1; daddr = 32'hA0; iaddr = 32'hB0;
        for (int k = 0; k < 10; k++) begin
            tick(); @(negedge CLK);
            chk("starve_is_i", ram_addr == iaddr, (k % 5) == 4);
        end
        tick(); clear_in();
        repeat (2) tick();

        // timeout with TIMEOUT=8
        dREN = 1; daddr = 32'h40;
        for (int c = 1; c <= 10; c++) begin
            tick(); @(negedge CLK);
            chk("to_err", err, c == 9);
            chk("to_ren", ram_ren, c != 9);
            chk("to_dwait", dwait, 1'b1);
        end
        tick(); clear_in();
        repeat (2) tick();

        // withdraw during instruction grant
        iREN = 1; iaddr = 32'h80;
        tick(); @(negedge CLK); chk("wd_ren", ram_ren, 1'b1);
        tick(); iREN = 0;
        tick(); @(negedge CLK);
        chk("wd_idle_ren", ram_ren, 1'b0); chk("wd_err", err, 1'b0);
        tick();

        // asynchronous reset mid-access
        dWEN = 1; daddr = 32'h44; dstore = 32'h99;
        tick(); @(negedge CLK); chk("rm_wen", ram_wen, 1'b1);
        #1 nRST = 1'b0;
        #1 chk("rm_wen_async", ram_wen, 1'b0); chk("rm_ren_async", ram_ren, 1'b0);
        tick(); clear_in(); nRST = 1'b1;
        @(negedge CLK); chk("rm_after_ren", ram_ren, 1'b0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            iREN = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: begin dREN = 1; dWEN = 0; end
                1: begin dREN = 0; dWEN = 1; end
                default: begin dREN = 0; dWEN = 0; end
            endcase
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
            ram_rdata = $urandom;
            ram_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                @(negedge CLK); #1 nRST = 1'b0;
                tick(); nRST = 1'b1;
            end
        end
        tick();
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
